// File: rtl/instr_mem_loader.sv
`default_nettype none
// ============================================================================
//  Module   : instr_mem_loader
//  Purpose  : Boot-time image writer for the byte-addressed, big-endian
//             instruction memory. Accepts 32-bit words on a valid/ready
//             stream and emits four byte writes per word, MSB first, while
//             holding the CPU in stall until a load completes.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk_i          rising-edge clock
//    rst_ni         asynchronous active-low reset
//    start_i        one-cycle load request (honoured in IDLE/DONE/ERROR only)
//    base_addr_i    first byte address of the image, sampled with start_i
//    word_count_i   number of words to load, sampled with start_i
//    in_valid_i     in_word_i carries a valid instruction word
//    in_word_i      instruction word, bit 31 is the MSB
//    in_ready_o     loader accepts in_word_i this cycle
//    wr_en_o        byte write strobe to the instruction memory
//    wr_addr_o      byte address of the write
//    wr_data_o      byte data of the write
//    busy_o         load in progress
//    done_o         load completed successfully (sticky until next start)
//    err_o          load rejected for alignment/range (sticky until next start)
//    cpu_hold_o     stall request to the PC/fetch logic
// ============================================================================
module instr_mem_loader #(
  parameter int MEM_BYTES = 400,
  parameter int CNT_W     = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [31:0]      base_addr_i,
  input  logic [CNT_W-1:0] word_count_i,
  input  logic             in_valid_i,
  input  logic [31:0]      in_word_i,
  output logic             in_ready_o,
  output logic             wr_en_o,
  output logic [31:0]      wr_addr_o,
  output logic [7:0]       wr_data_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic             cpu_hold_o
);

  // End-of-image address is formed 34 bits wide so base + 4*count can never
  // wrap and sneak past the range check.
  localparam int          c_SUM_W     = 34;
  localparam logic [33:0] c_MEM_LIMIT = 34'(MEM_BYTES);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_CHECK     = 3'd1,
    S_WAIT_WORD = 3'd2,
    S_WRITE     = 3'd3,
    S_DONE      = 3'd4,
    S_ERROR     = 3'd5
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      addr_q, addr_d;     // byte address of the current word
  logic [CNT_W-1:0] rem_q, rem_d;       // words still to be written
  logic [31:0]      word_q, word_d;     // word being split into bytes
  logic [1:0]       idx_q, idx_d;       // byte index within the word

  logic             in_ready_q, in_ready_d;
  logic             wr_en_q, wr_en_d;
  logic [31:0]      wr_addr_q, wr_addr_d;
  logic [7:0]       wr_data_q, wr_data_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             cpu_hold_q, cpu_hold_d;

  logic [33:0]      w_end_addr;
  logic             w_bad_align;
  logic             w_bad_range;
  logic             w_start_ok;
  logic [7:0]       w_byte_sel;

  assign w_end_addr  = {2'b00, addr_q}
                     + {{(c_SUM_W-CNT_W-2){1'b0}}, rem_q, 2'b00};
  assign w_bad_align = (addr_q[1:0] != 2'b00);
  assign w_bad_range = (w_end_addr > c_MEM_LIMIT);

  // A request is only honoured while no load is running.
  assign w_start_ok  = start_i &&
                       ((state_q == S_IDLE) || (state_q == S_DONE) ||
                        (state_q == S_ERROR));

  // --------------------------------------------------------------------------
  // Next-state and datapath
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    word_d  = word_q;
    idx_d   = idx_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (w_start_ok) begin
          addr_d  = base_addr_i;
          rem_d   = word_count_i;
          idx_d   = 2'd0;
          state_d = S_CHECK;
        end
      end

      S_CHECK: begin
        if (w_bad_align || w_bad_range) begin
          state_d = S_ERROR;
        end else if (rem_q == '0) begin
          state_d = S_DONE;
        end else begin
          state_d = S_WAIT_WORD;
        end
      end

      S_WAIT_WORD: begin
        // in_ready_q is high for the whole of this state, so in_valid_i
        // alone completes the handshake.
        if (in_valid_i) begin
          word_d  = in_word_i;
          idx_d   = 2'd0;
          state_d = S_WRITE;
        end
      end

      S_WRITE: begin
        if (idx_q == 2'd3) begin
          idx_d  = 2'd0;
          addr_d = addr_q + 32'd4;
          rem_d  = rem_q - {{(CNT_W-1){1'b0}}, 1'b1};
          if (rem_q == {{(CNT_W-1){1'b0}}, 1'b1}) begin
            state_d = S_DONE;
          end else begin
            state_d = S_WAIT_WORD;
          end
        end else begin
          idx_d = idx_q + 2'd1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output decode: outputs are registered from the next state so that they
  // line up with the state register rather than lagging it by a cycle.
  // --------------------------------------------------------------------------
  always_comb begin
    // Big-endian: byte 0 of a word is its most significant byte.
    w_byte_sel = 8'h00;
    case (idx_d)
      2'd0:    w_byte_sel = word_d[31:24];
      2'd1:    w_byte_sel = word_d[23:16];
      2'd2:    w_byte_sel = word_d[15:8];
      default: w_byte_sel = word_d[7:0];
    endcase
  end

  always_comb begin
    in_ready_d = (state_d == S_WAIT_WORD);
    wr_en_d    = (state_d == S_WRITE);
    wr_addr_d  = 32'd0;
    wr_data_d  = 8'h00;
    if (wr_en_d) begin
      wr_addr_d = addr_d + {30'd0, idx_d};
      wr_data_d = w_byte_sel;
    end
    busy_d     = (state_d == S_CHECK) || (state_d == S_WAIT_WORD) ||
                 (state_d == S_WRITE);
    done_d     = (state_d == S_DONE);
    err_d      = (state_d == S_ERROR);
    // The CPU runs only after a successful load; any new request stalls it.
    cpu_hold_d = (state_d != S_DONE);
  end

  // --------------------------------------------------------------------------
  // State and output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      addr_q     <= 32'd0;
      rem_q      <= '0;
      word_q     <= 32'd0;
      idx_q      <= 2'd0;
      in_ready_q <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= 32'd0;
      wr_data_q  <= 8'h00;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      cpu_hold_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      word_q     <= word_d;
      idx_q      <= idx_d;
      in_ready_q <= in_ready_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      cpu_hold_q <= cpu_hold_d;
    end
  end

  assign in_ready_o = in_ready_q;
  assign wr_en_o    = wr_en_q;
  assign wr_addr_o  = wr_addr_q;
  assign wr_data_o  = wr_data_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign err_o      = err_q;
  assign cpu_hold_o = cpu_hold_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_mem_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instr_mem_loader
//  Purpose  : Self-checking bench for instr_mem_loader. Expected byte writes
//             and completion status are derived from the load parameters and
//             the word list; DUT writes are captured into a bench-side memory.
//  Revision : 1.0  initial release
// ============================================================================
module tb_instr_mem_loader;

  localparam int MEM_BYTES = 400;
  localparam int CNT_W     = 16;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [31:0]      base_addr;
  logic [CNT_W-1:0] word_count;
  logic             in_valid;
  logic [31:0]      in_word;
  logic             in_ready;
  logic             wr_en;
  logic [31:0]      wr_addr;
  logic [7:0]       wr_data;
  logic             busy;
  logic             done;
  logic             err;
  logic             cpu_hold;

  instr_mem_loader #(.MEM_BYTES(MEM_BYTES), .CNT_W(CNT_W)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .start_i      (start),
    .base_addr_i  (base_addr),
    .word_count_i (word_count),
    .in_valid_i   (in_valid),
    .in_word_i    (in_word),
    .in_ready_o   (in_ready),
    .wr_en_o      (wr_en),
    .wr_addr_o    (wr_addr),
    .wr_data_o    (wr_data),
    .busy_o       (busy),
    .done_o       (done),
    .err_o        (err),
    .cpu_hold_o   (cpu_hold)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [7:0]  d;
  } wr_t;

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  wr_t         exp_q[$];
  logic [31:0] words[$];
  logic [7:0]  mem [0:MEM_BYTES-1];
  logic [31:0] last_addr = 32'hFFFF_FFFF;

  task automatic chk(input string tag, input logic [33:0] got, input logic [33:0] expv);
    total++;
    assert (got === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Capture every byte write and compare it against the expected sequence.
  always @(negedge clk) begin
    if (rst_n && wr_en) begin
      chk("wr_in_range", 34'(wr_addr < MEM_BYTES), 34'd1);
      if (wr_addr < MEM_BYTES) mem[wr_addr] = wr_data;
      last_addr = wr_addr;
      chk("wr_pending", 34'(exp_q.size() != 0), 34'd1);
      if (exp_q.size() != 0) begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", 34'(wr_addr), 34'(e.a));
        chk("wr_data", 34'(wr_data), 34'(e.d));
      end
    end
  end

  // Runs one complete load of the words in 'words'. gap > 0 holds in_valid
  // low for that many cycles after in_ready rises; poke pulses start with
  // junk parameters during a write cycle; exp_cycles < 0 skips the timing check.
  task automatic run_load(input logic [31:0] base, input int count, input int gap,
                          input bit poke, input int exp_cycles);
    longint end_addr;
    bit     exp_err;
    bit     poked;
    int     c_s;
    int     n;

    end_addr = longint'(base) + 4 * longint'(count);
    exp_err  = (base % 4 != 0) || (end_addr > MEM_BYTES);
    poked    = 1'b0;
    if (!exp_err) begin
      for (int i = 0; i < count; i++) begin
        for (int b = 0; b < 4; b++) begin
          wr_t e;
          e.a = base + 32'(4 * i + b);
          e.d = 8'((words[i] >> (24 - 8 * b)) & 32'hFF);
          exp_q.push_back(e);
        end
      end
    end

    c_s        = cyc;
    start      = 1'b1;
    base_addr  = base;
    word_count = CNT_W'(count);
    if (gap == 0 && count > 0 && !exp_err) begin
      in_valid = 1'b1;
      in_word  = words[0];
    end
    tick();
    start      = 1'b0;
    base_addr  = $urandom;
    word_count = CNT_W'($urandom);
    chk("start_busy", 34'(busy), 34'd1);
    chk("start_hold", 34'(cpu_hold), 34'd1);
    chk("start_clr_done", 34'(done | err), 34'd0);

    if (!exp_err) begin
      for (int i = 0; i < count; i++) begin
        if (gap > 0) begin
          n = 0;
          while (!in_ready && n < 60) begin tick(); n++; end
          chk("ready_rise", 34'(in_ready), 34'd1);
          for (int g = 0; g < gap; g++) begin
            chk("gap_ready", 34'(in_ready), 34'd1);
            chk("gap_no_wr", 34'(wr_en), 34'd0);
            tick();
          end
        end
        in_valid = 1'b1;
        in_word  = words[i];
        n = 0;
        while (!in_ready && n < 60) begin
          if (poke && wr_en && !poked) begin
            start      = 1'b1;
            base_addr  = 32'd2;
            word_count = CNT_W'(7);
            poked      = 1'b1;
          end
          tick();
          start = 1'b0;
          n++;
        end
        chk("handshake", 34'(in_ready), 34'd1);
        tick();
        if (gap > 0 || i == count - 1) in_valid = 1'b0;
      end
    end

    n = 0;
    while (!(done || err) && n < 60) begin tick(); n++; end
    chk("end_done", 34'(done), 34'(!exp_err));
    chk("end_err", 34'(err), 34'(exp_err));
    chk("end_hold", 34'(cpu_hold), 34'(exp_err));
    chk("end_busy", 34'(busy), 34'd0);
    if (exp_cycles >= 0) chk("end_latency", 34'(cyc - c_s), 34'(exp_cycles));
    if (poke) chk("poke_done", 34'(poked), 34'd1);
    tick();
    chk("writes_drained", 34'(exp_q.size()), 34'd0);
    if (!exp_err) begin
      for (int i = 0; i < count; i++) begin
        int a;
        a = int'(base) + 4 * i;
        chk("mem_word", 34'({mem[a], mem[a+1], mem[a+2], mem[a+3]}), 34'(words[i]));
      end
    end
  endtask

  initial begin
    int n;
    rst_n      = 1'b0;
    start      = 1'b0;
    base_addr  = 32'd0;
    word_count = '0;
    in_valid   = 1'b0;
    in_word    = 32'd0;
    tick();
    tick();
    chk("rst_wr_en", 34'(wr_en), 34'd0);
    chk("rst_ready", 34'(in_ready), 34'd0);
    chk("rst_status", 34'({busy, done, err}), 34'd0);
    chk("rst_hold", 34'(cpu_hold), 34'd1);
    rst_n = 1'b1;
    tick();

    // Basic two-word load with in_valid held high.
    words = '{32'h8C22_0004, 32'h0022_1820};
    run_load(32'd0, 2, 0, 1'b0, 12);
    chk("mem_at_4", 34'({mem[4], mem[5], mem[6], mem[7]}), 34'h0_0022_1820);

    // Same load under backpressure.
    run_load(32'd0, 2, 7, 1'b0, -1);

    // Range boundaries.
    words = '{32'h1111_2222, 32'h3333_4444, 32'h5555_6666};
    run_load(32'd392, 3, 0, 1'b0, 2);
    words = '{32'hDEAD_BEEF};
    run_load(32'd396, 1, 0, 1'b0, 7);
    chk("last_addr_399", 34'(last_addr), 34'd399);

    // Misalignment and empty load.
    run_load(32'd2, 1, 0, 1'b0, 2);
    run_load(32'd0, 0, 0, 1'b0, 2);

    // start pulsed during a write cycle must not disturb the load.
    words = '{$urandom, $urandom, $urandom};
    run_load(32'd100, 3, 0, 1'b1, 17);

    // Reset during byte 2 of word 1, then a clean restart.
    words = '{$urandom, $urandom, $urandom};
    for (int i = 0; i < 3; i++) begin
      for (int b = 0; b < 4; b++) begin
        wr_t e;
        e.a = 32'(40 + 4 * i + b);
        e.d = 8'((words[i] >> (24 - 8 * b)) & 32'hFF);
        exp_q.push_back(e);
      end
    end
    start      = 1'b1;
    base_addr  = 32'd40;
    word_count = CNT_W'(3);
    in_valid   = 1'b1;
    in_word    = words[0];
    tick();
    start = 1'b0;
    begin
      int k;
      k = 0;
      n = 0;
      while (!(wr_en && wr_addr == 32'd46) && n < 40) begin
        bit acc;
        acc = in_ready;
        tick();
        n++;
        if (acc) begin
          k++;
          in_word = words[(k < 3) ? k : 2];
        end
      end
    end
    chk("reached_mid_word", 34'(wr_en && wr_addr == 32'd46), 34'd1);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("arst_wr_en", 34'(wr_en), 34'd0);
    chk("arst_ready", 34'(in_ready), 34'd0);
    chk("arst_status", 34'({done, err}), 34'd0);
    chk("arst_hold", 34'(cpu_hold), 34'd1);
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_busy", 34'(busy), 34'd0);
    run_load(32'd40, 3, 0, 1'b0, 17);

    // Randomised loads: mix of near-top, unaligned and ordinary windows.
    for (int r = 0; r < 10; r++) begin
      int sel;
      int cnt;
      int gp;
      logic [31:0] b;
      sel = $urandom_range(0, 3);
      if (sel == 0)      b = 32'($urandom_range(90, 99) * 4);
      else if (sel == 1) b = 32'($urandom_range(0, 399));
      else               b = 32'($urandom_range(0, 60) * 4);
      cnt = $urandom_range(0, 5);
      gp  = $urandom_range(0, 3);
      words.delete();
      for (int i = 0; i < cnt; i++) words.push_back($urandom);
      if (gp == 0) begin
        if ((b % 4 != 0) || (longint'(b) + 4 * cnt > MEM_BYTES) || cnt == 0)
          run_load(b, cnt, 0, 1'b0, 2);
        else
          run_load(b, cnt, 0, 1'b0, 2 + 5 * cnt);
      end else begin
        run_load(b, cnt, gp, 1'b0, -1);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/instr_mem_loader.md
Name: instr_mem_loader

Overview:
Boot-time writer for the byte-addressed, big-endian instruction memory (MSB of each word at the lowest byte address).
- Accepts 32-bit instruction words over a valid/ready stream and splits each word into four sequential byte writes on the memory's byte write port.
- Holds the CPU in stall until the image is loaded.
- Sits between the host/testbench word source and the instruction memory write port; the fetch path keeps using the combinational read port.

Parameters:
MEM_BYTES, 400, size of the instruction memory in bytes; upper bound for all write addresses.
CNT_W, 16, width of the word-count input and the internal remaining-word counter.

Ports:
CLK  input  1  rising-edge clock.
RST_N  input  1  asynchronous active-low reset.
START  input  1  one-cycle load request; sampled only in IDLE, DONE or ERROR.
BASE_ADDR  input  32  first byte address of the image; sampled with START.
WORD_COUNT  input  CNT_W  number of words to load; sampled with START.
IN_VALID  input  1  IN_WORD holds a valid instruction word.
IN_WORD  input  32  instruction word, bit 31 = MSB.
IN_READY  output  1  loader accepts IN_WORD this cycle.
WR_EN  output  1  byte write strobe to instruction memory.
WR_ADDR  output  32  byte address for the write.
WR_DATA  output  8  byte data for the write.
BUSY  output  1  high while a load is in progress.
DONE  output  1  load completed successfully; held high.
ERR  output  1  load rejected (bad alignment or range); held high.
CPU_HOLD  output  1  stall request to the PC/fetch logic.

Behaviour:
- Clock and reset:
  - Single clock domain.
  - All outputs are registered.
  - RST_N low forces, asynchronously, state IDLE and all outputs 0 except CPU_HOLD = 1. The CPU stays stalled until the first successful load.
- States: IDLE, CHECK, WAIT_WORD, WRITE, DONE, ERROR.
- IDLE:
  - IN_READY = 0, WR_EN = 0, BUSY = 0.
  - START = 1 latches BASE_ADDR into addr_q and WORD_COUNT into rem_q, then goes to CHECK.
- CHECK (1 cycle), BUSY = 1:
  - If BASE_ADDR[1:0] != 0, or BASE_ADDR + 4*WORD_COUNT > MEM_BYTES, go to ERROR. The sum is computed 34 bits wide; no wrap-around.
  - Else if WORD_COUNT == 0, go to DONE.
  - Else go to WAIT_WORD.
- WAIT_WORD:
  - IN_READY = 1, BUSY = 1.
  - On IN_VALID & IN_READY: latch IN_WORD into word_q, set idx = 0, go to WRITE.
  - IN_VALID low causes an indefinite wait with no timeout.
- WRITE (exactly 4 cycles per word):
  - WR_EN = 1, WR_ADDR = addr_q + idx, WR_DATA = word_q[31-8*idx -: 8].
  - The byte order is therefore MSB first, matching the big-endian read path.
  - IN_READY = 0 throughout.
  - After idx = 3: addr_q += 4 and rem_q -= 1. If the new rem_q == 0, go to DONE; else go to WAIT_WORD.
- Throughput is 5 cycles per word when IN_VALID is held high (1 accept cycle + 4 write cycles).
- DONE:
  - DONE = 1, CPU_HOLD = 0, BUSY = 0.
  - Stays in DONE until START.
- ERROR:
  - ERR = 1, CPU_HOLD = 1, BUSY = 0.
  - No writes are issued.
  - Stays in ERROR until START.
- START taken from DONE or ERROR:
  - Clears DONE and ERR, sets CPU_HOLD = 1, and behaves as START from IDLE (goes to CHECK).
- START while BUSY is ignored; the latched parameters are unchanged.
- Reset mid-load:
  - WR_EN drops immediately (asynchronously).
  - A partially written word is left in memory as-is.
  - State returns to IDLE and the counters are cleared.
- Invariants:
  - WR_ADDR never reaches or exceeds MEM_BYTES while WR_EN = 1.
  - At most one byte is written per cycle.

Test Plan:
1. Reset with RST_N = 0 mid-simulation -> immediately WR_EN = 0, IN_READY = 0, DONE = 0, ERR = 0, CPU_HOLD = 1.
2. START with BASE_ADDR = 0, WORD_COUNT = 2; words 0x8C220004 then 0x00221820, IN_VALID held high -> byte writes 0x8C,0x22,0x00,0x04 at addresses 0..3, then 0x00,0x22,0x18,0x20 at 4..7; DONE = 1 and CPU_HOLD = 0 exactly 12 cycles after START (1 CHECK + 2×5 + 1); memory read at address 4 returns 0x00221820.
3. Backpressure: same load but IN_VALID low for 7 cycles before each word -> IN_READY stays high throughout the wait; the write sequence is identical, only delayed; no writes occur while waiting.
4. Range errors:
   - BASE_ADDR = 392, WORD_COUNT = 3 (needs 404 > 400) -> ERR = 1, no WR_EN pulses, CPU_HOLD stays 1.
   - BASE_ADDR = 396, WORD_COUNT = 1 -> accepted; last write is at address 399.
5. Alignment and empty load:
   - BASE_ADDR = 2 -> ERR = 1.
   - WORD_COUNT = 0 with BASE_ADDR = 0 -> DONE = 1 two cycles after START, no writes.
6. START pulsed during a WRITE cycle is ignored. Separately, RST_N is asserted during the byte with idx = 2 of word 1, then START is reissued -> the load restarts cleanly from BASE_ADDR and finishes with DONE = 1 and correct memory contents.
